// File: rtl/seq_detector_param_pkg.sv
// Shared symbol constants, event classification and width helper for the
// parametrised sequence detector.
package seq_det_pkg;

  localparam logic SYM_ZERO = 1'b0;
  localparam logic SYM_ONE  = 1'b1;

  typedef enum logic [1:0] {
    EV_IDLE,
    EV_ACCEPT,
    EV_ERROR,
    EV_TIMEOUT
  } event_e;

  // $clog2 yields 0 for values <= 1; registers still need at least one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_detector_param_btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for one button.
// The whole chain resets high so a button held through reset yields no edge.
module btn_sync_edge
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic meta;
  logic level;
  logic level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta    <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      rise    <= 1'b0;
    end else begin
      meta    <= btn;
      level   <= meta;
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Moore sequence detector: button edges enter symbols, the last PAT_LEN
// accepted symbols are compared against PATTERN, with timeout and error strobes.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter int                 TIMEOUT = 0,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p1,
  input  logic             p0,
  input  logic             overlap_en,
  input  logic             clr,
  output logic             z,
  output logic             match_pulse,
  output logic             err_pulse,
  output logic [CNT_W-1:0] match_count
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam int IDLE_W = clog2_min1(TIMEOUT + 1);
  localparam logic [FILL_W-1:0] FULL      = FILL_W'(PAT_LEN);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic rise1;
  logic rise0;

  btn_sync_edge u_sync_p1 (
    .clk   (clk),
    .reset (reset),
    .btn   (p1),
    .rise  (rise1)
  );

  btn_sync_edge u_sync_p0 (
    .clk   (clk),
    .reset (reset),
    .btn   (p0),
    .rise  (rise0)
  );

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_n;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_n;
  logic [IDLE_W-1:0]  idle;
  logic               hit;
  event_e             ev;

  // Candidate next history and the event class for this cycle; a timeout
  // only fires when no symbol edge competes with it.
  always_comb begin
    hist_n = {hist[PAT_LEN-2:0], rise1 ? SYM_ONE : SYM_ZERO};
    fill_n = (fill == FULL) ? FULL : fill + FILL_W'(1);
    hit    = (fill_n == FULL) && (hist_n == PATTERN);
    ev     = EV_IDLE;
    if (rise1 && rise0) begin
      ev = EV_ERROR;
    end else if (rise1 || rise0) begin
      ev = EV_ACCEPT;
    end else if ((TIMEOUT > 0) && (fill != '0) && (idle == IDLE_LAST)) begin
      ev = EV_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist        <= '0;
      fill        <= '0;
      idle        <= '0;
      z           <= 1'b0;
      match_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= 1'b0;
      err_pulse   <= 1'b0;
      if (clr) begin
        hist        <= '0;
        fill        <= '0;
        idle        <= '0;
        z           <= 1'b0;
        match_count <= '0;
      end else begin
        case (ev)
          EV_ACCEPT: begin
            hist        <= hist_n;
            idle        <= '0;
            z           <= hit;
            match_pulse <= hit;
            if (hit) begin
              // Non-overlapping mode restarts entry; the stale history is masked by fill.
              fill <= overlap_en ? FULL : '0;
              if (match_count != '1) begin
                match_count <= match_count + CNT_W'(1);
              end
            end else begin
              fill <= fill_n;
            end
          end
          EV_ERROR: begin
            fill      <= '0;
            idle      <= '0;
            z         <= 1'b0;
            err_pulse <= 1'b1;
          end
          EV_TIMEOUT: begin
            fill <= '0;
            idle <= '0;
            z    <= 1'b0;
          end
          default: begin
            idle <= ((TIMEOUT > 0) && (fill != '0)) ? idle + IDLE_W'(1) : '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: two detector instances (no timeout / 8-bit count and
// TIMEOUT=16 / 2-bit count) share stimulus and are checked against a symbol-level model.
module tb_seq_detector_param;

  localparam int             PAT_LEN = 4;
  localparam logic [3:0]     PAT     = 4'b1001;
  localparam int             TO_B    = 16;
  localparam int             CW_B    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic p1 = 1'b0;
  logic p0 = 1'b0;
  logic overlap_en = 1'b0;
  logic clr = 1'b0;

  logic       z_a, mp_a, ep_a;
  logic [7:0] cnt_a;
  logic       z_b, mp_b, ep_b;
  logic [CW_B-1:0] cnt_b;

  seq_detector_param #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .TIMEOUT(0), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .p1(p1), .p0(p0), .overlap_en(overlap_en), .clr(clr),
    .z(z_a), .match_pulse(mp_a), .err_pulse(ep_a), .match_count(cnt_a)
  );

  seq_detector_param #(.PAT_LEN(PAT_LEN), .PATTERN(PAT), .TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset), .p1(p1), .p0(p0), .overlap_en(overlap_en), .clr(clr),
    .z(z_b), .match_pulse(mp_b), .err_pulse(ep_b), .match_count(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    bit is_err;
    bit z;
    int cnt;
  } ev_t;

  ev_t  exp_q [2][$];
  bit   sym_q [2][$];
  bit   m_z [2];
  int   m_cnt [2];
  int   last_acc [2];
  int   tout [2] = '{0, TO_B};
  int   cmax [2] = '{255, (1 << CW_B) - 1};
  logic [3:0] pat = PAT;
  bit   lv1_q [$];
  bit   lv0_q [$];
  int   edge_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic model_reset();
    lv1_q = '{1, 1, 1, 1, 1};
    lv0_q = '{1, 1, 1, 1, 1};
    for (int i = 0; i < 2; i++) begin
      sym_q[i].delete();
      exp_q[i].delete();
      m_z[i]      = 1'b0;
      m_cnt[i]    = 0;
      last_acc[i] = 0;
    end
  endtask

  // Symbol-level rules: accept, clear on error/clr, discard stale partial entry.
  task automatic model_step(input int i, input bit r1, input bit r0);
    ev_t e;
    bit  hit;
    if (clr) begin
      sym_q[i].delete();
      m_z[i]   = 1'b0;
      m_cnt[i] = 0;
    end else if (r1 && r0) begin
      sym_q[i].delete();
      m_z[i] = 1'b0;
      e = '{edge_no: edge_cnt, is_err: 1'b1, z: 1'b0, cnt: m_cnt[i]};
      exp_q[i].push_back(e);
    end else if (r1 || r0) begin
      sym_q[i].push_back(r1);
      if (sym_q[i].size() > PAT_LEN) void'(sym_q[i].pop_front());
      last_acc[i] = edge_cnt;
      hit = (sym_q[i].size() == PAT_LEN);
      for (int j = 0; j < sym_q[i].size(); j++)
        if (sym_q[i][j] != pat[PAT_LEN-1-j]) hit = 1'b0;
      m_z[i] = hit;
      if (hit) begin
        if (m_cnt[i] < cmax[i]) m_cnt[i]++;
        e = '{edge_no: edge_cnt, is_err: 1'b0, z: 1'b1, cnt: m_cnt[i]};
        exp_q[i].push_back(e);
        if (!overlap_en) sym_q[i].delete();
      end
    end else if (tout[i] > 0 && sym_q[i].size() > 0 && edge_cnt - last_acc[i] == tout[i]) begin
      sym_q[i].delete();
      m_z[i] = 1'b0;
    end
  endtask

  // A button contributes a symbol three edges after its level is first sampled high.
  always @(posedge clk or posedge reset) begin
    bit r1, r0;
    if (reset) begin
      model_reset();
    end else begin
      edge_cnt++;
      lv1_q.push_back(p1);
      lv0_q.push_back(p0);
      void'(lv1_q.pop_front());
      void'(lv0_q.pop_front());
      r1 = lv1_q[1] && !lv1_q[0];
      r0 = lv0_q[1] && !lv0_q[0];
      for (int i = 0; i < 2; i++) model_step(i, r1, r0);
    end
  end

  task automatic check_pulse(input int i, input bit mp, input bit ep, input bit zv, input int cnt);
    ev_t e;
    if (mp || ep) begin
      vectors++;
      if (exp_q[i].size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_pulse inst%0d edge %0d: got mp=%0b ep=%0b, required no pulse",
                 i, edge_cnt, mp, ep);
      end else begin
        e = exp_q[i].pop_front();
        if (e.edge_no != edge_cnt || mp != !e.is_err || ep != e.is_err || zv != e.z || cnt != e.cnt) begin
          miscompares++;
          $display("[TB] FAIL pulse inst%0d: got edge=%0d mp=%0b ep=%0b z=%0b cnt=%0d, required edge=%0d mp=%0b ep=%0b z=%0b cnt=%0d",
                   i, edge_cnt, mp, ep, zv, cnt, e.edge_no, !e.is_err, e.is_err, e.z, e.cnt);
        end
      end
    end else if (exp_q[i].size() > 0 && exp_q[i][0].edge_no <= edge_cnt) begin
      e = exp_q[i].pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL missed_pulse inst%0d: got no pulse at edge %0d, required %s pulse from edge %0d",
               i, edge_cnt, e.is_err ? "err" : "match", e.edge_no);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check_pulse(0, mp_a, ep_a, z_a, int'(cnt_a));
      check_pulse(1, mp_b, ep_b, z_b, int'(cnt_b));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input bit v1, input bit v0, input int n);
    p1 = v1;
    p0 = v0;
    tick(n);
  endtask

  task automatic press(input bit s);
    apply_stimulus(s, !s, 5);
    apply_stimulus(1'b0, 1'b0, 5);
  endtask

  task automatic press_seq(input string s);
    for (int k = 0; k < s.len(); k++) press(s[k] == "1");
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
  endtask

  task automatic check_output(input string name);
    int act_cnt [2];
    bit act_z [2];
    act_cnt[0] = int'(cnt_a);
    act_cnt[1] = int'(cnt_b);
    act_z[0]   = z_a;
    act_z[1]   = z_b;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (act_z[i] != m_z[i] || act_cnt[i] != m_cnt[i]) begin
        miscompares++;
        $display("[TB] FAIL %s inst%0d: got z=%0b count=%0d, required z=%0b count=%0d",
                 name, i, act_z[i], act_cnt[i], m_z[i], m_cnt[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(2);
    check_output("reset_state");

    // Basic non-overlapping match, then a breaking symbol.
    press_seq("1001");
    check_output("basic_match");
    press(1'b0);
    check_output("after_extra_zero");

    // Overlap versus non-overlap on 1001001.
    pulse_clr();
    overlap_en = 1'b1;
    press_seq("1001001");
    check_output("overlap_two");
    pulse_clr();
    overlap_en = 1'b0;
    press_seq("1001001");
    check_output("nonoverlap_one");

    // Simultaneous edges flag an error and restart entry.
    pulse_clr();
    press_seq("10");
    apply_stimulus(1'b1, 1'b1, 5);
    apply_stimulus(1'b0, 1'b0, 5);
    check_output("err_restart");
    press_seq("01");
    check_output("err_partial");
    press_seq("1001");
    check_output("err_full");

    // Long idle discards partial entry only in the timeout instance.
    pulse_clr();
    press_seq("100");
    apply_stimulus(1'b0, 1'b0, 20);
    press(1'b1);
    check_output("timeout_long_gap");
    press_seq("001");
    check_output("timeout_fill_one");
    pulse_clr();
    press_seq("1001");
    check_output("timeout_short_gap");

    // Held buttons give one symbol, including when held across reset.
    pulse_clr();
    press(1'b1);
    apply_stimulus(1'b0, 1'b1, 50);
    apply_stimulus(1'b0, 1'b0, 5);
    press_seq("01");
    check_output("hold_single");
    p1 = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    check_output("reset_hold");
    apply_stimulus(1'b0, 1'b0, 5);
    press_seq("001");
    check_output("reset_hold_ignored");
    press_seq("1001");
    check_output("reset_hold_repress");

    // Saturation of the narrow counter and clr.
    pulse_clr();
    overlap_en = 1'b1;
    press(1'b1);
    repeat (6) press_seq("001");
    check_output("count_saturate");
    pulse_clr();
    check_output("clr_state");

    // Randomised levels, idles and clears.
    for (int blk = 0; blk < 8; blk++) begin
      pulse_clr();
      overlap_en = $urandom_range(0, 1);
      for (int seg = 0; seg < 60; seg++) begin
        if ($urandom_range(0, 49) == 0) begin
          clr = 1'b1;
          apply_stimulus($urandom_range(0, 1), $urandom_range(0, 1), 1);
          clr = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          apply_stimulus(1'b0, 1'b0, $urandom_range(12, 24));
        end else begin
          apply_stimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 6));
        end
        if (seg % 15 == 14) check_output("random_levels");
      end
    end

    apply_stimulus(1'b0, 1'b0, 10);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (exp_q[i].size() != 0) begin
        miscompares++;
        $display("[TB] FAIL pending_events inst%0d: got %0d unmatched, required 0", i, exp_q[i].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
